pio_debounce_irq: RTL and testbench

Parametrised Avalon-MM parallel I/O peripheral for the Nios II system, replacing the separate fixed single-bit LED, switch and key PIOs with one block. It drives IN_WIDTH debounced inputs and OUT_WIDTH outputs. It adds per-channel debounce, edge capture, an interrupt mask and a level interrupt to the CPU. The block sits on the system interconnect as an Avalon-MM slave with fixed read latency 1.

---
 rtl/pio_debounce_irq_pkg.sv | 14 +
 rtl/pio_debounce_ch.sv | 41 ++++
 rtl/pio_debounce_irq.sv | 97 +++++++++
 tb/tb_pio_debounce_irq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_debounce_irq_pkg.sv
// Shared constants for the debounced PIO peripheral: register word addresses
// and the encodings accepted by the EDGE_MODE parameter.
package pio_debounce_irq_pkg;

  localparam logic [1:0] ADDR_DATA_IN  = 2'd0;
  localparam logic [1:0] ADDR_DATA_OUT = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: two-flop synchroniser, a debounce counter and the
// accepted (stable) level.
module pio_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] count;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level, and restarts from zero on any agreement or acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      count  <= '0;
      stable <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        count <= '0;
      end else if (count == TERMINAL) begin
        stable <= sync_2;
        count  <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pio_debounce_irq.sv
// Avalon-MM parallel I/O block: debounced inputs with edge capture and a
// masked level interrupt, plus an output register; read latency is one cycle.
module pio_debounce_irq
  import pio_debounce_irq_pkg::*;
#(
  parameter int          IN_WIDTH        = 4,
  parameter int          OUT_WIDTH       = 8,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_MODE       = EDGE_RISING,
  parameter logic [31:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam logic [OUT_WIDTH-1:0] OUT_RST = OUT_RESET[OUT_WIDTH-1:0];

  logic [IN_WIDTH-1:0]  data_in;
  logic [IN_WIDTH-1:0]  data_in_q;
  logic [IN_WIDTH-1:0]  edge_set;
  logic [IN_WIDTH-1:0]  cap_clear;
  logic [IN_WIDTH-1:0]  edge_cap;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [OUT_WIDTH-1:0] data_out;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_ch
    pio_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw   (in_port[i]),
      .stable(data_in[i])
    );
  end

  always_comb begin
    edge_set = '0;
    case (EDGE_MODE)
      EDGE_FALLING: edge_set = ~data_in & data_in_q;
      EDGE_ANY:     edge_set = data_in ^ data_in_q;
      default:      edge_set = data_in & ~data_in_q;
    endcase
  end

  always_comb begin
    cap_clear = '0;
    if (avs_write && avs_address == ADDR_EDGE_CAP)
      cap_clear = avs_writedata[IN_WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = data_in;
      ADDR_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = data_out;
      ADDR_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask;
      ADDR_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap;
    endcase
  end

  // A new edge is ORed in after the clear so it survives a same-cycle clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_out     <= OUT_RST;
      irq_mask     <= '0;
      edge_cap     <= '0;
      data_in_q    <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (avs_write && avs_address == ADDR_DATA_OUT)
        data_out <= avs_writedata[OUT_WIDTH-1:0];
      if (avs_write && avs_address == ADDR_IRQ_MASK)
        irq_mask <= avs_writedata[IN_WIDTH-1:0];
      edge_cap  <= (edge_cap & ~cap_clear) | edge_set;
      data_in_q <= data_in;
      irq       <= |(edge_cap & irq_mask);
      if (avs_read)
        avs_readdata <= rd_mux;
    end
  end

  assign out_port     = data_out;
  assign unused_wdata = ^avs_writedata;

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Directed bench for pio_debounce_irq with DEBOUNCE_CYCLES=4, IN_WIDTH=4,
// OUT_WIDTH=8, rising-edge capture; inputs driven and outputs sampled on negedge.
module tb_pio_debounce_irq;

  logic        clk_clk;
  logic        reset_reset_n;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [3:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  int vectors;
  int miscompares;

  pio_debounce_irq #(
    .IN_WIDTH       (4),
    .OUT_WIDTH      (8),
    .DEBOUNCE_CYCLES(4),
    .EDGE_MODE      (0),
    .OUT_RESET      (32'h0)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .in_port      (in_port),
    .out_port     (out_port),
    .irq          (irq)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  // Bus tasks are entered on a negedge and leave on the following negedge.
  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write     = 1'b0;
    avs_writedata = '0;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d        = avs_readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    vectors++;
    if (out_port !== 8'h00 || irq !== 1'b0 || avs_readdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got out=%h irq=%b rd=%h, expected 00 0 0", out_port, irq, avs_readdata);
    end
    for (int a = 0; a < 4; a++) begin
      av_read(2'(a), d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_read_addr%0d: got %h, expected 00000000", a, d);
      end
    end
  endtask

  task automatic test_data_out();
    logic [31:0] d;
    av_write(2'd1, 32'hA5);
    vectors++;
    if (out_port !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL out_port_a5: got %h, expected a5", out_port);
    end
    av_read(2'd1, d);
    vectors++;
    if (d !== 32'h000000A5) begin
      miscompares++;
      $display("[TB] FAIL read_data_out_a5: got %h, expected 000000a5", d);
    end
    av_write(2'd1, 32'h1FF);
    vectors++;
    if (out_port !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL out_port_ff: got %h, expected ff", out_port);
    end
    vectors++;
    if (avs_readdata !== 32'h000000A5) begin
      miscompares++;
      $display("[TB] FAIL readdata_hold: got %h, expected 000000a5", avs_readdata);
    end
    av_read(2'd1, d);
    vectors++;
    if (d !== 32'h000000FF) begin
      miscompares++;
      $display("[TB] FAIL read_data_out_ff: got %h, expected 000000ff", d);
    end
    av_write(2'd0, 32'hF);
    av_read(2'd0, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL data_in_write_ignored: got %h, expected 00000000", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port[0] = 1'b1;
    idle(3);
    in_port[0] = 1'b0;
    idle(10);
    av_read(2'd0, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL glitch_data_in: got %h, expected 00000000", d);
    end
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL glitch_edge_cap: got cap=%h irq=%b, expected 00000000 0", d, irq);
    end
  endtask

  task automatic test_irq_clear();
    logic [31:0] d;
    av_write(2'd2, 32'h1);
    in_port[0] = 1'b1;
    idle(5);
    av_read(2'd0, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL data_in_before_latency: got %h, expected 00000000", d);
    end
    av_read(2'd0, d);
    vectors++;
    if (d !== 32'h1 || irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL data_in_at_latency: got %h irq=%b, expected 00000001 0", d, irq);
    end
    @(negedge clk_clk);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL irq_rise: got %b, expected 1", irq);
    end
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("[TB] FAIL edge_cap_ch0: got %h, expected 00000001", d);
    end
    av_write(2'd3, 32'h1);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL irq_hold_after_clear: got %b, expected 1", irq);
    end
    @(negedge clk_clk);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL irq_fall_after_clear: got %b, expected 0", irq);
    end
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL edge_cap_cleared: got %h, expected 00000000", d);
    end
    in_port[0] = 1'b0;
    idle(10);
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL falling_not_captured: got cap=%h irq=%b, expected 00000000 0", d, irq);
    end
  endtask

  task automatic test_multi_channel();
    logic [31:0] d;
    av_write(2'd2, 32'h2);
    in_port = 4'b1010;
    idle(10);
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'hA || irq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL edge_cap_ch1_ch3: got cap=%h irq=%b, expected 0000000a 1", d, irq);
    end
    av_read(2'd0, d);
    vectors++;
    if (d !== 32'hA) begin
      miscompares++;
      $display("[TB] FAIL data_in_ch1_ch3: got %h, expected 0000000a", d);
    end
    av_write(2'd3, 32'h2);
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'h8 || irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL partial_clear: got cap=%h irq=%b, expected 00000008 0", d, irq);
    end
    av_read(2'd2, d);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("[TB] FAIL irq_mask_read: got %h, expected 00000002", d);
    end
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    in_port[2] = 1'b1;
    idle(6);
    av_write(2'd3, 32'hC);
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'h4) begin
      miscompares++;
      $display("[TB] FAIL set_beats_clear: got %h, expected 00000004", d);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] d;
    in_port[0] = 1'b1;
    idle(3);
    #2 reset_reset_n = 1'b0;
    #1;
    vectors++;
    if (out_port !== 8'h00 || irq !== 1'b0 || avs_readdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got out=%h irq=%b rd=%h, expected 00 0 0", out_port, irq, avs_readdata);
    end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    idle(6);
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL no_early_capture: got %h, expected 00000000", d);
    end
    av_read(2'd3, d);
    vectors++;
    if (d !== 32'hF) begin
      miscompares++;
      $display("[TB] FAIL capture_after_debounce: got %h, expected 0000000f", d);
    end
    av_read(2'd2, d);
    vectors++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mask_after_reset: got mask=%h irq=%b, expected 00000000 0", d, irq);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_reset_n = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    in_port       = '0;
    idle(2);
    reset_reset_n = 1'b1;
    test_reset();
    test_data_out();
    test_glitch();
    test_irq_clear();
    test_multi_channel();
    test_set_beats_clear();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
